// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package bus_pkg;

  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_MASK_W = BUS_DATA_W / 8;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  write;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_MASK_W-1:0] wmask;
  } bus_req_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Returns the master index (0/1) to grant; only meaningful when v0 or v1 is set.
  function automatic logic pick_winner(input logic v0, input logic v1,
                                       input logic last_grant, input logic fair);
    if (v0 && v1) begin
      return fair ? ~last_grant : 1'b0;
    end
    return v1 & ~v0;
  endfunction

endpackage

// File: rtl/bus_req_slot.sv
// One-deep request holding register for a single master.
module bus_req_slot
  import bus_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     load_i,
  input  bus_req_t req_i,
  input  logic     clear_i,
  output logic     valid_o,
  output bus_req_t req_o
);

  logic     valid_q, valid_d;
  bus_req_t req_q, req_d;

  // A load into a full slot is dropped; a slot cleared this edge accepts a load next cycle.
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end
    if (load_i && !valid_q) begin
      valid_d = 1'b1;
      req_d   = req_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin (or fixed-priority) arbiter for the data bus, one transaction
// in flight, with a timeout that completes the transaction with an error.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter bit          FAIR    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  m0_request,
  input  logic [BUS_ADDR_W-1:0] m0_addr,
  input  logic                  m0_write,
  input  logic [BUS_DATA_W-1:0] m0_wdata,
  input  logic [BUS_MASK_W-1:0] m0_wmask,
  output logic [BUS_DATA_W-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_error,

  input  logic                  m1_request,
  input  logic [BUS_ADDR_W-1:0] m1_addr,
  input  logic                  m1_write,
  input  logic [BUS_DATA_W-1:0] m1_wdata,
  input  logic [BUS_MASK_W-1:0] m1_wmask,
  output logic [BUS_DATA_W-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_error,

  output logic                  bus_request,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic                  bus_write,
  output logic [BUS_DATA_W-1:0] bus_wdata,
  output logic [BUS_MASK_W-1:0] bus_wmask,
  input  logic                  bus_ack,
  input  logic [BUS_DATA_W-1:0] bus_rdata
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  bus_req_t req0, req1, slot0, slot1;
  logic     valid0, valid1, clear0, clear1, winner;

  assign req0 = '{addr: m0_addr, write: m0_write, wdata: m0_wdata, wmask: m0_wmask};
  assign req1 = '{addr: m1_addr, write: m1_write, wdata: m1_wdata, wmask: m1_wmask};

  bus_req_slot u_slot0 (
    .clock   (clock),
    .reset   (reset),
    .load_i  (m0_request),
    .req_i   (req0),
    .clear_i (clear0),
    .valid_o (valid0),
    .req_o   (slot0)
  );

  bus_req_slot u_slot1 (
    .clock   (clock),
    .reset   (reset),
    .load_i  (m1_request),
    .req_i   (req1),
    .clear_i (clear1),
    .valid_o (valid1),
    .req_o   (slot1)
  );

  arb_state_t            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [15:0]           timer_q, timer_d;
  bus_req_t              bus_q, bus_d;
  logic                  bus_request_q, bus_request_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;

  assign winner = pick_winner(valid0, valid1, last_grant_q, FAIR);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    bus_d         = bus_q;
    bus_request_d = 1'b0;
    ack_d         = 2'b00;
    err_d         = 2'b00;
    rdata_d       = '0;
    clear0        = 1'b0;
    clear1        = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // bus_ack seen here is late or spurious and is dropped.
        if (valid0 || valid1) begin
          bus_request_d = 1'b1;
          bus_d         = winner ? slot1 : slot0;
          last_grant_d  = winner;
          timer_d       = '0;
          state_d       = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // The wait is counted from the cycle after the bus_request pulse.
        if (!bus_request_q) begin
          timer_d = timer_q + 16'd1;
        end
        if (bus_ack || timer_q == TimeoutLast) begin
          ack_d[last_grant_q] = 1'b1;
          err_d[last_grant_q] = ~bus_ack;
          rdata_d             = bus_ack ? bus_rdata : '0;
          clear0              = ~last_grant_q;
          clear1              = last_grant_q;
          state_d             = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= 1'b1;
      timer_q       <= '0;
      bus_q         <= '0;
      bus_request_q <= 1'b0;
      ack_q         <= 2'b00;
      err_q         <= 2'b00;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      bus_q         <= bus_d;
      bus_request_q <= bus_request_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus_request = bus_request_q;
  assign bus_addr    = bus_q.addr;
  assign bus_write   = bus_q.write;
  assign bus_wdata   = bus_q.wdata;
  assign bus_wmask   = bus_q.wmask;

  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_error = err_q[0];
  assign m1_error = err_q[1];
  assign m0_rdata = ack_q[0] ? rdata_q : '0;
  assign m1_rdata = ack_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: instance a is round-robin, instance b fixed-priority, both TIMEOUT=16.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_request = 1'b0, m1_request = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic        m0_write = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;

  logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic        a_m0_ack, a_m0_error, a_m1_ack, a_m1_error, a_bus_request, a_bus_write, a_bus_ack;
  logic [3:0]  a_bus_wmask;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata, b_bus_rdata;
  logic        b_m0_ack, b_m0_error, b_m1_ack, b_m1_error, b_bus_request, b_bus_write, b_bus_ack;
  logic [3:0]  b_bus_wmask;

  // Device model: acks one cycle after bus_request (auto) or on a hand-driven pulse.
  logic        a_auto = 1'b1, a_man_ack = 1'b0;
  logic        a_req_dly = 1'b0, b_req_dly = 1'b0;
  logic [31:0] dev_rdata = '0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    a_req_dly <= a_bus_request;
    b_req_dly <= b_bus_request;
  end

  assign a_bus_ack   = a_auto ? a_req_dly : a_man_ack;
  assign a_bus_rdata = a_bus_ack ? dev_rdata : '0;
  assign b_bus_ack   = b_req_dly;
  assign b_bus_rdata = b_bus_ack ? dev_rdata : '0;

  bus_arbiter #(.TIMEOUT(16), .FAIR(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .m0_request(m0_request), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_error(a_m0_error),
    .m1_request(m1_request), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_error(a_m1_error),
    .bus_request(a_bus_request), .bus_addr(a_bus_addr), .bus_write(a_bus_write),
    .bus_wdata(a_bus_wdata), .bus_wmask(a_bus_wmask), .bus_ack(a_bus_ack),
    .bus_rdata(a_bus_rdata)
  );

  bus_arbiter #(.TIMEOUT(16), .FAIR(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .m0_request(m0_request), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_error(b_m0_error),
    .m1_request(m1_request), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_error(b_m1_error),
    .bus_request(b_bus_request), .bus_addr(b_bus_addr), .bus_write(b_bus_write),
    .bus_wdata(b_bus_wdata), .bus_wmask(b_bus_wmask), .bus_ack(b_bus_ack),
    .bus_rdata(b_bus_rdata)
  );

  logic [31:0] a_out_or, b_out_or;
  assign a_out_or = a_bus_addr | a_bus_wdata | a_m0_rdata | a_m1_rdata |
                    {22'b0, a_bus_request, a_bus_write, a_bus_wmask,
                     a_m0_ack, a_m0_error, a_m1_ack, a_m1_error};
  assign b_out_or = b_bus_addr | b_bus_wdata | b_m0_rdata | b_m1_rdata |
                    {22'b0, b_bus_request, b_bus_write, b_bus_wmask,
                     b_m0_ack, b_m0_error, b_m1_ack, b_m1_error};

  int n_checks = 0;
  int n_fail   = 0;
  int grants[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge(s); request and manual-ack pulses last one cycle.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      m0_request = 1'b0;
      m1_request = 1'b0;
      a_man_ack  = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic req(input int m, input logic [31:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic [3:0] mask);
    if (m == 0) begin
      m0_request = 1'b1; m0_addr = addr; m0_write = wr; m0_wdata = wdata; m0_wmask = mask;
    end else begin
      m1_request = 1'b1; m1_addr = addr; m1_write = wr; m1_wdata = wdata; m1_wmask = mask;
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check_eq("rst_a_outputs", a_out_or, 32'h0);
    check_eq("rst_b_outputs", b_out_or, 32'h0);
    reset = 1'b0;
    tick(1);
    check_eq("idle_a_outputs", a_out_or, 32'h0);

    // 1) m0 read, device acks one cycle after bus_request
    do_reset();
    dev_rdata = 32'hDEAD_BEEF;
    req(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
    tick(1);
    check_eq("t1_no_req_n1", {31'b0, a_bus_request}, 32'd0);
    tick(1);
    check_eq("t1_bus_req_n2", {31'b0, a_bus_request}, 32'd1);
    check_eq("t1_bus_addr", a_bus_addr, 32'h0000_0100);
    check_eq("t1_bus_write", {31'b0, a_bus_write}, 32'd0);
    tick(1);
    check_eq("t1_no_ack_n3", {31'b0, a_m0_ack}, 32'd0);
    tick(1);
    check_eq("t1_ack_n4", {30'b0, a_m0_ack, a_m1_ack}, 32'b10);
    check_eq("t1_rdata", a_m0_rdata, 32'hDEAD_BEEF);
    check_eq("t1_error", {31'b0, a_m0_error}, 32'd0);
    tick(1);
    check_eq("t1_ack_gone", {31'b0, a_m0_ack}, 32'd0);
    check_eq("t1_rdata_zero", a_m0_rdata, 32'h0);

    // 2) simultaneous requests: m0 first, m1 three cycles later
    do_reset();
    dev_rdata = 32'h0BAD_F00D;
    req(0, 32'h0000_1000, 1'b1, 32'hA5A5_0000, 4'hF);
    req(1, 32'h0000_2000, 1'b0, 32'h0, 4'hF);
    tick(2);
    check_eq("t2_a_req0", {31'b0, a_bus_request}, 32'd1);
    check_eq("t2_a_addr0", a_bus_addr, 32'h0000_1000);
    check_eq("t2_a_wdata0", a_bus_wdata, 32'hA5A5_0000);
    check_eq("t2_a_wr_mask0", {27'b0, a_bus_write, a_bus_wmask}, {27'b0, 1'b1, 4'hF});
    check_eq("t2_b_addr0", b_bus_addr, 32'h0000_1000);
    tick(1);
    check_eq("t2_held", {a_bus_addr[31:1], a_bus_request}, {31'h0000_0800, 1'b0});
    tick(1);
    check_eq("t2_m0_ack", {30'b0, a_m0_ack, a_m1_ack}, 32'b10);
    tick(1);
    check_eq("t2_a_req1", {31'b0, a_bus_request}, 32'd1);
    check_eq("t2_a_addr1", a_bus_addr, 32'h0000_2000);
    tick(2);
    check_eq("t2_m1_ack", {30'b0, a_m0_ack, a_m1_ack}, 32'b01);
    check_eq("t2_m1_rdata", a_m1_rdata, 32'h0BAD_F00D);

    // 3) continuous contention, each master re-requests in its ack cycle
    do_reset();
    req(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
    req(1, 32'h0000_2000, 1'b0, 32'h0, 4'hF);
    for (int c = 0; c < 36; c++) begin
      tick(1);
      if (a_bus_request) grants.push_back(a_bus_addr == 32'h0000_2000 ? 1 : 0);
      m0_request = a_m0_ack;
      m1_request = a_m1_ack;
    end
    tick(8);
    check_eq("t3_grant_count", {31'b0, grants.size() >= 10}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("t3_alt_%0d", i),
               (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    end

    // 3b) after an m0 grant, a tie goes to m1 when fair and to m0 under fixed priority
    do_reset();
    req(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
    tick(4);
    check_eq("t3b_first_acks", {30'b0, a_m0_ack, b_m0_ack}, 32'b11);
    tick(1);
    req(0, 32'h0000_3000, 1'b0, 32'h0, 4'hF);
    req(1, 32'h0000_2000, 1'b0, 32'h0, 4'hF);
    tick(2);
    check_eq("t3b_reqs", {30'b0, a_bus_request, b_bus_request}, 32'b11);
    check_eq("t3b_fair_m1", a_bus_addr, 32'h0000_2000);
    check_eq("t3b_prio_m0", b_bus_addr, 32'h0000_3000);

    // 4) m1 write times out, then a stray bus_ack is ignored
    do_reset();
    a_auto = 1'b0;
    req(1, 32'h4000_0000, 1'b1, 32'h1234_5678, 4'b0011);
    tick(2);
    check_eq("t4_bus_req", {31'b0, a_bus_request}, 32'd1);
    check_eq("t4_bus_fields", {a_bus_wdata[27:0], a_bus_write, a_bus_wmask[2:0]},
             {28'h234_5678, 1'b1, 3'b011});
    tick(8);
    check_eq("t4_addr_held", a_bus_addr, 32'h4000_0000);
    check_eq("t4_no_ack_b8", {31'b0, a_m1_ack}, 32'd0);
    tick(8);
    check_eq("t4_no_ack_b16", {31'b0, a_m1_ack}, 32'd0);
    tick(1);
    check_eq("t4_timeout_b17", {28'b0, a_m0_ack, a_m0_error, a_m1_ack, a_m1_error}, 32'b0011);
    check_eq("t4_rdata_zero", a_m1_rdata, 32'h0);
    tick(1);
    check_eq("t4_err_gone", {30'b0, a_m1_ack, a_m1_error}, 32'b00);
    tick(2);
    dev_rdata = 32'hFFFF_0000;
    a_man_ack = 1'b1;
    tick(1);
    check_eq("t4_spurious_1", {28'b0, a_m0_ack, a_m0_error, a_m1_ack, a_m1_error}, 32'b0);
    tick(1);
    check_eq("t4_spurious_2", {29'b0, a_m0_ack, a_m1_ack, a_bus_request}, 32'b0);
    a_auto = 1'b1;

    // 5) m0 re-requests in its ack cycle
    do_reset();
    dev_rdata = 32'h1111_1111;
    req(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
    tick(4);
    check_eq("t5_ack1", {31'b0, a_m0_ack}, 32'd1);
    check_eq("t5_rdata1", a_m0_rdata, 32'h1111_1111);
    req(0, 32'h0000_0200, 1'b0, 32'h0, 4'hF);
    dev_rdata = 32'h2222_2222;
    tick(2);
    check_eq("t5_bus_req2", {31'b0, a_bus_request}, 32'd1);
    check_eq("t5_addr2", a_bus_addr, 32'h0000_0200);
    tick(2);
    check_eq("t5_ack2", {31'b0, a_m0_ack}, 32'd1);
    check_eq("t5_rdata2", a_m0_rdata, 32'h2222_2222);

    // 6) reset while busy, with the device ack landing during reset
    do_reset();
    a_auto = 1'b0;
    req(0, 32'h0000_0500, 1'b0, 32'h0, 4'hF);
    tick(2);
    check_eq("t6_busy_req", {31'b0, a_bus_request}, 32'd1);
    tick(1);
    reset = 1'b1;
    tick(1);
    a_man_ack = 1'b1;
    check_eq("t6_in_reset", a_out_or, 32'h0);
    tick(1);
    reset = 1'b0;
    check_eq("t6_after_reset", a_out_or, 32'h0);
    tick(1);
    check_eq("t6_quiet_1", a_out_or, 32'h0);
    tick(1);
    check_eq("t6_quiet_2", a_out_or, 32'h0);
    a_auto    = 1'b1;
    dev_rdata = 32'hCAFE_F00D;
    req(1, 32'h0000_0600, 1'b0, 32'h0, 4'hF);
    tick(2);
    check_eq("t6_new_req", {31'b0, a_bus_request}, 32'd1);
    check_eq("t6_new_addr", a_bus_addr, 32'h0000_0600);
    tick(2);
    check_eq("t6_new_ack", {29'b0, a_m0_ack, a_m1_ack, a_m1_error}, 32'b010);
    check_eq("t6_new_rdata", a_m1_rdata, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
